// File: rtl/vertex_translate_pkg.sv
// Shared vertex arithmetic: difference width, coordinate type and the
// narrowing conversion used by the translate and projection stages.
package vertex_pkg;

  localparam int DEF_VERT_W    = 6;
  localparam int DEF_CAM_W     = 7;
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_NUM_VERTS = 3;
  localparam int DEF_DIMS      = 3;
  localparam bit DEF_SATURATE  = 1'b1;

  // Wide enough to carry any difference or converted coordinate.
  localparam int COORD_W = 32;
  typedef logic signed [COORD_W-1:0] coord_t;

  // One extra bit over the wider operand keeps a - b exact.
  function automatic int diff_width(input int vert_w, input int cam_w);
    return ((vert_w > cam_w) ? vert_w : cam_w) + 1;
  endfunction

  // Narrow a difference to out_w bits. When out_w is at least the
  // difference width the value always fits, so neither branch alters it.
  function automatic coord_t sat_conv(input coord_t d, input int out_w,
                                      input bit saturate, output logic clamped);
    coord_t hi;
    coord_t lo;
    coord_t res;
    hi      = (coord_t'(1) <<< (out_w - 1)) - coord_t'(1);
    lo      = -hi - coord_t'(1);
    clamped = 1'b0;
    if (saturate) begin
      if (d > hi) begin
        res     = hi;
        clamped = 1'b1;
      end else if (d < lo) begin
        res     = lo;
        clamped = 1'b1;
      end else begin
        res = d;
      end
    end else begin
      res = (d <<< (COORD_W - out_w)) >>> (COORD_W - out_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/vertex_translate_if.sv
// Triangle stream plus camera-load port between vertex fetch, the
// translate stage and the projection front end.
interface vertex_translate_if
  import vertex_pkg::*;
#(
  parameter int VERT_W    = DEF_VERT_W,
  parameter int CAM_W     = DEF_CAM_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int NUM_VERTS = DEF_NUM_VERTS,
  parameter int DIMS      = DEF_DIMS
);

  logic                              cam_valid_in;
  logic [DIMS*CAM_W-1:0]             cam_pos_in;
  logic                              tri_valid_in;
  logic                              tri_ready_out;
  logic [NUM_VERTS*DIMS*VERT_W-1:0]  tri_in;
  logic                              tri_valid_out;
  logic                              tri_ready_in;
  logic [NUM_VERTS*DIMS*OUT_W-1:0]   tri_out;
  logic                              sat_out;

  modport slave (
    input  cam_valid_in, cam_pos_in, tri_valid_in, tri_in, tri_ready_in,
    output tri_ready_out, tri_valid_out, tri_out, sat_out
  );

  modport master (
    output cam_valid_in, cam_pos_in, tri_valid_in, tri_in, tri_ready_in,
    input  tri_ready_out, tri_valid_out, tri_out, sat_out
  );

endinterface

// File: rtl/vertex_translate_coord_sub_sat.sv
// Single-coordinate datapath: exact subtract for the first stage and the
// narrowing conversion for the second, both purely combinational.
module coord_sub_sat
  import vertex_pkg::*;
#(
  parameter int VERT_W   = DEF_VERT_W,
  parameter int CAM_W    = DEF_CAM_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter bit SATURATE = DEF_SATURATE,
  localparam int D_W     = diff_width(VERT_W, CAM_W)
) (
  input  logic signed [VERT_W-1:0] vert,
  input  logic signed [CAM_W-1:0]  cam,
  output logic signed [D_W-1:0]    diff,
  input  logic signed [D_W-1:0]    diff_q,
  output logic signed [OUT_W-1:0]  conv,
  output logic                     clamped
);

  always_comb begin
    diff = D_W'(vert) - D_W'(cam);
  end

  // Conversion works on the registered difference, not this cycle's.
  always_comb begin
    clamped = 1'b0;
    conv    = OUT_W'(sat_conv(coord_t'(diff_q), OUT_W, SATURATE, clamped));
  end

endmodule

// File: rtl/vertex_translate.sv
// Two-stage camera-space translation: S1 holds exact differences, S2 holds
// converted coordinates; one global enable stalls both stages together.
module vertex_translate
  import vertex_pkg::*;
#(
  parameter int VERT_W    = DEF_VERT_W,
  parameter int CAM_W     = DEF_CAM_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int NUM_VERTS = DEF_NUM_VERTS,
  parameter int DIMS      = DEF_DIMS,
  parameter bit SATURATE  = DEF_SATURATE
) (
  input logic               clk_in,
  input logic               rst_in,
  vertex_translate_if.slave bus
);

  localparam int D_W = diff_width(VERT_W, CAM_W);
  localparam int NC  = NUM_VERTS * DIMS;

  logic [DIMS*CAM_W-1:0] cam_q;
  logic [NC*D_W-1:0]     diff_d;
  logic [NC*D_W-1:0]     diff_q1;
  logic [NC*OUT_W-1:0]   conv_d;
  logic [NC*OUT_W-1:0]   out_q2;
  logic [NC-1:0]         clamp_d;
  logic                  valid_q1;
  logic                  valid_q2;
  logic                  sat_q2;
  logic                  en;

  for (genvar v = 0; v < NUM_VERTS; v++) begin : g_vert
    for (genvar d = 0; d < DIMS; d++) begin : g_dim
      localparam int C = v * DIMS + d;
      coord_sub_sat #(
        .VERT_W   (VERT_W),
        .CAM_W    (CAM_W),
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
      ) u_coord (
        .vert    (bus.tri_in[C*VERT_W +: VERT_W]),
        .cam     (cam_q[d*CAM_W +: CAM_W]),
        .diff    (diff_d[C*D_W +: D_W]),
        .diff_q  (diff_q1[C*D_W +: D_W]),
        .conv    (conv_d[C*OUT_W +: OUT_W]),
        .clamped (clamp_d[C])
      );
    end
  end

  assign en                = !valid_q2 || bus.tri_ready_in;
  assign bus.tri_ready_out = en;
  assign bus.tri_valid_out = valid_q2;
  assign bus.tri_out       = out_q2;
  assign bus.sat_out       = sat_q2;

  // The camera register loads regardless of stall; an accept in the same
  // cycle still sees the old value because diff_d is built from cam_q.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cam_q    <= '0;
      diff_q1  <= '0;
      valid_q1 <= 1'b0;
      out_q2   <= '0;
      sat_q2   <= 1'b0;
      valid_q2 <= 1'b0;
    end else begin
      if (bus.cam_valid_in) begin
        cam_q <= bus.cam_pos_in;
      end
      if (en) begin
        diff_q1  <= diff_d;
        valid_q1 <= bus.tri_valid_in;
        out_q2   <= conv_d;
        sat_q2   <= valid_q1 && (|clamp_d);
        valid_q2 <= valid_q1;
      end
    end
  end

endmodule
